seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the single-cycle datapath ALU. It executes the established 16-operation function set at full width (`WIDTH`) or half width (`WIDTH/2`) and keeps a persistent flag register whose carry feeds ADC and the rotate operations. An optional multi-cycle unsigned multiplier can be compiled in. It sits between the register-file read ports and the write-back stage, with valid/ready on both sides so the control unit can stall it.

## Interface
- `WIDTH`, 32, datapath width; must be even and ≥ 4. `H = WIDTH/2`.
- `clock`  in  1  single clock; rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block accepts a request this cycle.
- `input_a`  in  WIDTH  operand A.
- `input_b`  in  WIDTH  operand B.
- `FunSel`  in  5  [4]=1 full width, 0 half width; [3:0] selects the operation.
- `ext`  in  1  1 = extended op (multiply); `FunSel` is ignored.
- `flag_we`  in  1  write flags when this operation completes.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes the result.
- `ALUOut`  out  WIDTH  result; product low half for multiply.
- `out_hi`  out  WIDTH  product high half; 0 for all other operations.
- `flags`  out  4  {Z,C,N,V}, registered.
- `illegal`  out  1  1-cycle pulse when `ext` is accepted but the multiplier is not compiled in.

## Operation
- Transfer occurs on `in_valid & in_ready`; `in_ready = (state==IDLE) | (state==DONE & out_ready)`.
- Operands, `FunSel`, `ext` and `flag_we` are captured at accept.
- The result is registered and held stable until `out_ready`.
- States:
  - IDLE → DONE on accept of a non-multiply op.
  - IDLE → MUL on accept of a multiply.
  - MUL → DONE after `WIDTH` iterations.
  - DONE → IDLE on `out_ready` with no new accept.
  - DONE stays in DONE or goes to MUL on `out_ready` with a simultaneous accept.
- Op codes for `FunSel[3:0]`: 0 pass A, 1 pass B, 2 NOT A, 3 NOT B, 4 A+B, 5 A+B+C, 6 A−B, 7 AND, 8 OR, 9 XOR, A NAND, B LSL, C LSR, D ASR, E CSL {A[n-2:0],C}, F CSR {C,A[n-1:1]}.
- Half-width ops use only bits [H-1:0] of each operand; the result is zero-extended to `WIDTH`. `n` = H or WIDTH according to `FunSel[4]`.
- C used by ops 5, E and F is `flags[2]` as it stood at accept.
- Flags are computed from the new result at width `n`:
  - Z = result[n-1:0]==0.
  - N = result[n-1].
  - C: ops 4/5 give carry-out of bit n-1; op 6 gives no-borrow (A ≥ B unsigned); B/E give A[n-1]; C/D/F give A[0]; all other ops leave C unchanged.
  - V: ops 4/5 set V = (A[n-1]==B[n-1]) & (R[n-1]!=A[n-1]); op 6 sets V = (A[n-1]!=B[n-1]) & (R[n-1]!=A[n-1]); all other ops set V = 0.
- Multiply: unsigned, radix-2 shift-add, 2·WIDTH-bit product. Flags: Z = product==0, N = product[2W-1], C = (out_hi!=0), V = 0.
- `flags` is updated on the DONE-entry edge only when the captured `flag_we` = 1.

## Timing
- Non-multiply latency: `out_valid` rises 1 cycle after accept. Back-to-back throughput is 1 op/cycle when `out_ready` is held at 1.
- Multiply latency: `WIDTH`+1 cycles from accept to `out_valid`. `in_ready` = 0 while in MUL.
- Reset (async assert, sync release):
  - state = IDLE.
  - `ALUOut`, `out_hi`, `flags` = 0.
  - `out_valid`, `illegal` = 0.
  - `in_ready` = 1 on the first cycle after release.
- Reset mid-multiply aborts the operation; no result or flag update follows.
- With `out_ready` = 0 in DONE, all outputs are held and `in_ready` = 0.
- Flags written by op k are visible as the carry source for op k+1, including in back-to-back issue.

## Configuration
- `SEQ_ALU_MUL_EN` defined: MUL state and multiplier datapath are present; `ext` requests multiply.
- Not defined: no multiplier logic. An accepted `ext` goes to DONE in 1 cycle with `ALUOut` = `out_hi` = 0, flags unchanged, and `illegal` pulsed on the DONE-entry cycle.

## Test plan
- WIDTH=32, FunSel=10100, A=FFFFFFFF, B=1, flag_we=1 → ALUOut=0, flags Z=1 C=1 N=0 V=0.
- FunSel=00110, A=0000_8000, B=0000_0001 (half width) → ALUOut=0000_7FFF, C=1, N=0, V=1.
- Carry chain: op 10100 with A=FFFFFFFF, B=1 (sets C), then FunSel=10101, A=B=0 issued back-to-back with out_ready=1 → second ALUOut=1. Then FunSel=11111, A=0 → ALUOut=0 (C was cleared by the ADC).
- out_ready low for 3 cycles in DONE → ALUOut and flags stable, in_ready=0; new op accepted on the cycle out_ready rises.
- With `SEQ_ALU_MUL_EN`: ext=1, A=FFFFFFFF, B=FFFFFFFF → after 33 cycles out_hi=FFFFFFFE, ALUOut=00000001, C=1, N=1. Without the macro: same stimulus → 1-cycle result of 0 and an `illegal` pulse.
- Assert reset_n low during MUL cycle 10 → outputs 0 immediately; after release, in_ready=1 and no out_valid appears.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operand request channel and result channel,
// each with its own valid/ready pair.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [4:0]       FunSel;
    logic             ext;
    logic             flag_we;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUOut;
    logic [WIDTH-1:0] out_hi;
    logic [3:0]       flags;
    logic             illegal;

    modport master (
        output in_valid, input_a, input_b, FunSel, ext, flag_we, out_ready,
        input  in_ready, out_valid, ALUOut, out_hi, flags, illegal
    );

    modport slave (
        input  in_valid, input_a, input_b, FunSel, ext, flag_we, out_ready,
        output in_ready, out_valid, ALUOut, out_hi, flags, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// Handshaked 16-op ALU (full or half width) with persistent {Z,C,N,V} flags.
// Define SEQ_ALU_MUL_EN to build in the WIDTH-cycle shift-add unsigned multiplier.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    seq_alu_if.slave   bus
);
    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0] L_MASK_H = {{H{1'b0}}, {H{1'b1}}};
    localparam logic [WIDTH-1:0] L_TOP_F  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] L_TOP_H  = {{H{1'b0}}, 1'b1, {(H-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_aluout;
    logic [WIDTH-1:0] r_out_hi;
    logic [3:0]       r_flags;
    logic             r_illegal;

    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH+3:0] w_alu;

    // Returns {Z,C,N,V,result}; operands are masked to n bits first so that every
    // half-width result comes out already zero-extended.
    function automatic logic [WIDTH+3:0] f_alu(
        input logic [WIDTH-1:0] a_in,
        input logic [WIDTH-1:0] b_in,
        input logic [3:0]       op,
        input logic             full,
        input logic             cin
    );
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] top;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        logic [WIDTH:0]   sum;
        logic             ci;
        logic             co;
        logic             am;
        logic             bm;
        logic             rm;
        logic             z;
        logic             c;
        logic             n;
        logic             v;
        mask = full ? '1 : L_MASK_H;
        top  = full ? L_TOP_F : L_TOP_H;
        a    = a_in & mask;
        b    = b_in & mask;
        am   = full ? a[WIDTH-1] : a[H-1];
        bm   = full ? b[WIDTH-1] : b[H-1];
        ci   = (op == 4'h5) & cin;
        sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        co   = full ? sum[WIDTH] : sum[H];
        case (op)
            4'h0:       r = a;
            4'h1:       r = b;
            4'h2:       r = ~a;
            4'h3:       r = ~b;
            4'h4, 4'h5: r = sum[WIDTH-1:0];
            4'h6:       r = a - b;
            4'h7:       r = a & b;
            4'h8:       r = a | b;
            4'h9:       r = a ^ b;
            4'hA:       r = ~(a & b);
            4'hB:       r = a << 1;
            4'hC:       r = a >> 1;
            4'hD:       r = (a >> 1) | (am ? top : '0);
            4'hE:       r = (a << 1) | {{(WIDTH-1){1'b0}}, cin};
            4'hF:       r = (a >> 1) | (cin ? top : '0);
            default:    r = a;
        endcase
        r  = r & mask;
        rm = full ? r[WIDTH-1] : r[H-1];
        z  = (r == '0);
        n  = rm;
        c  = cin;
        v  = 1'b0;
        case (op)
            4'h4, 4'h5: begin
                c = co;
                v = (am == bm) & (rm != am);
            end
            4'h6: begin
                c = (a >= b);
                v = (am != bm) & (rm != am);
            end
            4'hB, 4'hE:       c = am;
            4'hC, 4'hD, 4'hF: c = a[0];
            default: ;
        endcase
        return {z, c, n, v, r};
    endfunction

    assign w_in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_alu      = f_alu(bus.input_a, bus.input_b, bus.FunSel[3:0], bus.FunSel[4], r_flags[2]);

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      r_cnt;
    logic               r_flag_we;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     w_psum;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic               w_mul_last;

    // {hi, lo} starts as {0, B}; each step conditionally adds A into hi and shifts right.
    assign w_psum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_nxt = {w_psum, r_prod[WIDTH-1:1]};
    assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (w_accept && bus.ext) begin
            r_mcand <= bus.input_a;
            r_prod  <= {{WIDTH{1'b0}}, bus.input_b};
        end else if (r_state == S_MUL) begin
            r_prod  <= w_prod_nxt;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_aluout    <= '0;
            r_out_hi    <= '0;
            r_flags     <= '0;
            r_illegal   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_cnt       <= '0;
            r_flag_we   <= 1'b0;
`endif
        end else begin
            r_illegal <= 1'b0;
            if (w_accept) begin
                if (bus.ext) begin
`ifdef SEQ_ALU_MUL_EN
                    r_state     <= S_MUL;
                    r_out_valid <= 1'b0;
                    r_cnt       <= '0;
                    r_flag_we   <= bus.flag_we;
`else
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                    r_aluout    <= '0;
                    r_out_hi    <= '0;
                    r_illegal   <= 1'b1;
`endif
                end else begin
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                    r_aluout    <= w_alu[WIDTH-1:0];
                    r_out_hi    <= '0;
                    if (bus.flag_we) begin
                        r_flags <= w_alu[WIDTH+3:WIDTH];
                    end
                end
            end else begin
                case (r_state)
`ifdef SEQ_ALU_MUL_EN
                    S_MUL: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_mul_last) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_aluout    <= w_prod_nxt[WIDTH-1:0];
                            r_out_hi    <= w_prod_nxt[2*WIDTH-1:WIDTH];
                            if (r_flag_we) begin
                                r_flags <= {(w_prod_nxt == '0), (w_prod_nxt[2*WIDTH-1:WIDTH] != '0),
                                            w_prod_nxt[2*WIDTH-1], 1'b0};
                            end
                        end
                    end
`endif
                    S_DONE: begin
                        if (bus.out_ready) begin
                            r_state     <= S_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.ALUOut    = r_aluout;
    assign bus.out_hi    = r_out_hi;
    assign bus.flags     = r_flags;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=32: vector table through a result scoreboard, plus
// stall, extended-op and reset-abort sequences (expectations follow SEQ_ALU_MUL_EN).
module tb_seq_alu;
    localparam int W = 32;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] hi;
        logic [3:0]  fl;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [4:0]  fs;
        logic [31:0] a;
        logic [31:0] b;
        logic        fwe;
        logic [31:0] r;
        logic [3:0]  fl;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic [31:0] hi,
                                input logic [3:0] fl, input logic ill);
        exp_t e;
        e.r = r; e.hi = hi; e.fl = fl; e.ill = ill;
        return e;
    endfunction

    function automatic void add(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                                input logic fwe, input logic [31:0] r, input logic [3:0] fl);
        vec_t v;
        v.fs = fs; v.a = a; v.b = b; v.fwe = fwe; v.r = r; v.fl = fl;
        vecs.push_back(v);
    endfunction

    task automatic issue(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                         input logic e, input logic fwe, input exp_t ex, output int waited);
        bit ok;
        ok     = 1'b0;
        waited = 0;
        bus.FunSel   = fs;
        bus.input_a  = a;
        bus.input_b  = b;
        bus.ext      = e;
        bus.flag_we  = fwe;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 required 1");
        end else begin
            sb.push_back(ex);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clock) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got ALUOut %h required no output", bus.ALUOut);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("out%0d_ALUOut", n_out), 64'(bus.ALUOut), 64'(e.r));
                chk($sformatf("out%0d_out_hi", n_out), 64'(bus.out_hi), 64'(e.hi));
                chk($sformatf("out%0d_flags", n_out), 64'(bus.flags), 64'(e.fl));
                chk($sformatf("out%0d_illegal", n_out), 64'(bus.illegal), 64'(e.ill));
                n_out++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt;
        int seen;
        int exp_lat;

        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.input_a  = '0;
        bus.input_b  = '0;
        bus.FunSel   = '0;
        bus.ext      = 1'b0;
        bus.flag_we  = 1'b0;

        // fs, A, B, flag_we, expected ALUOut, expected {Z,C,N,V}; flags chain through the list
        add(5'b00110, 32'h0000_8000, 32'h0000_0001, 1, 32'h0000_7FFF, 4'h5);
        add(5'b10100, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 4'hC);
        add(5'b10101, 32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0001, 4'h0);
        add(5'b11111, 32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0000, 4'h8);
        add(5'b10000, 32'h8000_0000, 32'h0000_0000, 1, 32'h8000_0000, 4'h2);
        add(5'b10001, 32'h0000_0000, 32'h1234_5678, 1, 32'h1234_5678, 4'h0);
        add(5'b10010, 32'h0F0F_0F0F, 32'h0000_0000, 1, 32'hF0F0_F0F0, 4'h2);
        add(5'b00011, 32'h0000_0000, 32'h0000_FFFF, 1, 32'h0000_0000, 4'h8);
        add(5'b10100, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 4'h3);
        add(5'b10110, 32'h0000_0001, 32'h0000_0002, 1, 32'hFFFF_FFFF, 4'h2);
        add(5'b10110, 32'h0000_0005, 32'h0000_0005, 1, 32'h0000_0000, 4'hC);
        add(5'b10111, 32'hFF00_FF00, 32'h0F0F_0F0F, 1, 32'h0F00_0F00, 4'h4);
        add(5'b11000, 32'hF000_0000, 32'h0000_000F, 1, 32'hF000_000F, 4'h6);
        add(5'b11001, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 32'h0000_0000, 4'hC);
        add(5'b11010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 4'hC);
        add(5'b11011, 32'h8000_0001, 32'h0000_0000, 1, 32'h0000_0002, 4'h4);
        add(5'b11100, 32'h0000_0003, 32'h0000_0000, 1, 32'h0000_0001, 4'h4);
        add(5'b11101, 32'h8000_0002, 32'h0000_0000, 1, 32'hC000_0001, 4'h2);
        add(5'b01101, 32'hFFFF_8000, 32'h0000_0000, 1, 32'h0000_C000, 4'h2);
        add(5'b11110, 32'h8000_0000, 32'h0000_0000, 1, 32'h0000_0000, 4'hC);
        add(5'b01110, 32'h0000_1234, 32'h0000_0000, 1, 32'h0000_2469, 4'h0);
        add(5'b01111, 32'h0000_0001, 32'h0000_0000, 1, 32'h0000_0000, 4'hC);
        add(5'b10100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 4'hC);
        add(5'b00101, 32'h0000_FFFF, 32'h0000_0000, 1, 32'h0000_0000, 4'hC);
        add(5'b00100, 32'hFFFF_7FFF, 32'h1234_0001, 1, 32'h0000_8000, 4'h3);

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_ALUOut", 64'(bus.ALUOut), 64'd0);
        chk("rst_out_hi", 64'(bus.out_hi), 64'd0);
        chk("rst_flags", 64'(bus.flags), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            issue(vecs[i].fs, vecs[i].a, vecs[i].b, 1'b0, vecs[i].fwe,
                  mk(vecs[i].r, 32'h0, vecs[i].fl, 1'b0), w);
        end
        drain("drain_table");

        // Stall in DONE, then release with a new request in the same cycle
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        issue(5'b10001, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, mk(32'hDEAD_BEEF, 32'h0, 4'h2, 1'b0), w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("stall%0d_ALUOut", i), 64'(bus.ALUOut), 64'hDEAD_BEEF);
            chk($sformatf("stall%0d_flags", i), 64'(bus.flags), 64'h2);
            chk($sformatf("stall%0d_in_ready", i), 64'(bus.in_ready), 64'd0);
            chk($sformatf("stall%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
        end
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        issue(5'b10000, 32'h0000_0055, 32'h0, 1'b0, 1'b1, mk(32'h0000_0055, 32'h0, 4'h0, 1'b0), w);
        chk("accept_on_ready_rise", 64'(w), 64'd0);
        issue(5'b11001, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 1'b1, mk(32'h0, 32'h0, 4'h8, 1'b0), w);

        // Extended op: multiply when built in, otherwise an illegal 1-cycle no-op
`ifdef SEQ_ALU_MUL_EN
        exp_lat = W + 1;
        issue(5'b00000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1,
              mk(32'h0000_0001, 32'hFFFF_FFFE, 4'h6, 1'b0), w);
`else
        exp_lat = 1;
        issue(5'b00000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1,
              mk(32'h0, 32'h0, 4'h8, 1'b1), w);
`endif
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            cnt++;
            if (bus.out_valid) break;
        end
        chk("ext_latency", 64'(cnt), 64'(exp_lat));
        @(negedge clock);
        chk("ext_illegal_after", 64'(bus.illegal), 64'd0);
        drain("drain_ext");

        // Reset while busy: outputs clear at once and the aborted op never completes
        @(posedge clock);
        #1;
`ifdef SEQ_ALU_MUL_EN
        issue(5'b00000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1,
              mk(32'h0000_0001, 32'hFFFF_FFFE, 4'h6, 1'b0), w);
`else
        bus.out_ready = 1'b0;
        issue(5'b10001, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, mk(32'hCAFE_F00D, 32'h0, 4'h2, 1'b0), w);
`endif
        repeat (9) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("abort_ALUOut", 64'(bus.ALUOut), 64'd0);
        chk("abort_out_hi", 64'(bus.out_hi), 64'd0);
        chk("abort_flags", 64'(bus.flags), 64'd0);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.out_valid) seen++;
        end
        chk("abort_no_output", 64'(seen), 64'd0);

        @(posedge clock);
        #1;
        issue(5'b10101, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, mk(32'h0000_0002, 32'h0, 4'h0, 1'b0), w);
        drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
